// File: rtl/cache_mem_ctrl.sv
// Direct-mapped write-back cache controller between a CPU word port and a 128-bit line memory.
// Optional hit/miss statistics counters are built in when CACHE_STATS_EN is defined.
module cache_mem_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpuReq,
  input  logic         cpuWe,
  input  logic [9:0]   cpuAddr,
  input  logic [31:0]  cpuWData,
  output logic [31:0]  cpuRData,
  output logic         cpuReady,
  output logic         isMemRead,
  output logic         isLock,
  output logic [9:0]   address,
  output logic [127:0] writeData,
  output logic [3:0]   isDirty,
  input  logic [127:0] readData
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  hitCount,
  output logic [15:0]  missCount
`endif
);
  // state     | meaning
  // IDLE      | waiting for cpuReq
  // COMPARE   | tag check; hit completes, miss starts a memory transfer
  // WRITEBACK | dirty victim sent to memory, isLock low MEM_LAT cycles
  // GAP       | one locked cycle switching the port from write to read
  // ALLOCATE  | refill from memory, isLock low MEM_LAT cycles
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COMPARE   = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] ALLOCATE  = 3'd4;

  localparam int IW      = $clog2(NUM_LINES);
  localparam int TAG_W   = 8 - IW;
  localparam int TIMER_W = $clog2(MEM_LAT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(MEM_LAT - 1);

  logic [2:0]                 state;
  logic [TIMER_W-1:0]         timer;
  logic [9:0]                 req_addr;
  logic                       req_we;
  logic [31:0]                req_wdata;
  logic                       refilled;
  logic [NUM_LINES-1:0]       valid;
  logic [NUM_LINES-1:0][3:0]  dirty;
  logic [TAG_W-1:0]           tag_q  [NUM_LINES];
  logic [127:0]               line_q [NUM_LINES];

  logic [IW-1:0]    req_idx, acc_idx;
  logic [TAG_W-1:0] req_tag, acc_tag;
  logic [1:0]       req_off;
  logic             hit, victim_dirty, acc_writeback;

  always_comb begin
    req_idx       = req_addr[IW+1:2];
    req_tag       = req_addr[9:IW+2];
    req_off       = req_addr[1:0];
    acc_idx       = cpuAddr[IW+1:2];
    acc_tag       = cpuAddr[9:IW+2];
    hit           = valid[req_idx] && (tag_q[req_idx] == req_tag);
    victim_dirty  = valid[req_idx] && (|dirty[req_idx]);
    acc_writeback = valid[acc_idx] && (|dirty[acc_idx]) && (tag_q[acc_idx] != acc_tag);
  end

  // Memory-side outputs are set up at accept time (isLock still high) so they
  // never move while the memory is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      refilled  <= 1'b0;
      valid     <= '0;
      dirty     <= '0;
      cpuReady  <= 1'b0;
      cpuRData  <= '0;
      isLock    <= 1'b1;
      isMemRead <= 1'b1;
      address   <= '0;
      writeData <= '0;
      isDirty   <= '0;
`ifdef CACHE_STATS_EN
      hitCount  <= '0;
      missCount <= '0;
`endif
    end else begin
      cpuReady <= 1'b0;
      case (state)
        IDLE: if (cpuReq) begin
          req_addr  <= cpuAddr;
          req_we    <= cpuWe;
          req_wdata <= cpuWData;
          refilled  <= 1'b0;
          state     <= COMPARE;
          if (acc_writeback) begin
            address   <= {tag_q[acc_idx], acc_idx, 2'b00};
            isMemRead <= 1'b0;
            writeData <= line_q[acc_idx];
            isDirty   <= dirty[acc_idx];
          end else begin
            address   <= {acc_tag, acc_idx, 2'b00};
            isMemRead <= 1'b1;
            isDirty   <= '0;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpuReady <= 1'b1;
            if (req_we) dirty[req_idx][req_off] <= 1'b1;
            else        cpuRData <= line_q[req_idx][{~req_off, 5'b00000} +: 32];
            state <= IDLE;
          end else begin
            isLock <= 1'b0;
            timer  <= TIMER_LOAD;
            state  <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
`ifdef CACHE_STATS_EN
          if (!refilled) begin
            if (hit && hitCount != 16'hFFFF)    hitCount  <= hitCount + 16'd1;
            if (!hit && missCount != 16'hFFFF)  missCount <= missCount + 16'd1;
          end
`endif
        end
        WRITEBACK: begin
          if (timer == '0) begin
            isLock         <= 1'b1;
            dirty[req_idx] <= '0;
            address        <= {req_tag, req_idx, 2'b00};
            isMemRead      <= 1'b1;
            isDirty        <= '0;
            state          <= GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          isLock <= 1'b0;
          timer  <= TIMER_LOAD;
          state  <= ALLOCATE;
        end
        ALLOCATE: begin
          if (timer == '0) begin
            isLock         <= 1'b1;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= '0;
            refilled       <= 1'b1;
            state          <= COMPARE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage and tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && timer == '0) begin
      line_q[req_idx] <= readData;
      tag_q[req_idx]  <= req_tag;
    end else if (state == COMPARE && hit && req_we) begin
      line_q[req_idx][{~req_off, 5'b00000} +: 32] <= req_wdata;
    end
  end
endmodule
